mux4x1_rr: RTL
==============

MUX4X1_RR -- requirements
Module: mux4x1_rr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of every data path.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port x_i, input, 4 x DATA_W: channel data, x_i[k] belongs to channel k.
REQ-005 The block SHALL have port valid_i, input, 4 bits: per-channel valid.
REQ-006 The block SHALL have port ready_o, output, 4 bits: per-channel ready; a transfer on channel k occurs when valid_i[k] and ready_o[k] are both 1 at a rising edge.
REQ-007 The block SHALL have port y_o, output, DATA_W: merged output data.
REQ-008 The block SHALL have port sel_o, output, 2 bits: channel index the current y_o came from.
REQ-009 The block SHALL have port valid_o, output, 1 bit: y_o/sel_o hold a word.
REQ-010 The block SHALL have port ready_i, input, 1 bit: downstream accepts; a transfer occurs when valid_o and ready_i are both 1 at a rising edge.

Function
REQ-011 The block SHALL hold one output register (y_o, sel_o, valid_o); load_en = !valid_o | ready_i.
REQ-012 The block SHALL grant, among channels with valid_i=1, the first found scanning from priority pointer ptr upward modulo 4 (ptr, ptr+1, ..., 3, 0, ...).
REQ-013 ready_o[k] SHALL be 1 only when load_en=1, valid_i[k]=1 and k is the granted channel; at most one ready_o bit SHALL be 1 per cycle.
REQ-014 On an input transfer on channel k, the block SHALL load y_o<=x_i[k], sel_o<=k, valid_o<=1 at that edge: latency 1 cycle, throughput 1 word per cycle.
REQ-015 On an input transfer on channel k, ptr SHALL become (k+1) mod 4, with wrap 3->0.
REQ-016 If load_en=1 and no valid_i bit is set, valid_o SHALL go to 0 at the edge, and ptr, y_o and sel_o SHALL hold.
REQ-017 While valid_o=1 and ready_i=0, y_o, sel_o, valid_o and ptr SHALL remain stable and all ready_o SHALL be 0.
REQ-018 Output consumption and a new input transfer in the same cycle SHALL both occur, with no bubble.
REQ-019 With all four channels continuously valid and ready_i=1, the grant order SHALL be 0,1,2,3,0,... and no channel SHALL wait more than 3 transfers.
REQ-020 ready_o SHALL depend combinationally only on valid_i, ready_i, valid_o and ptr, and never on x_i.

Reset
REQ-021 When rst_ni=0 at a rising edge, the block SHALL set valid_o=0, y_o=0, sel_o=0 and ptr=0.
REQ-022 ready_o SHALL be 0 while rst_ni=0.
REQ-023 A word held in the output register when reset is asserted SHALL be discarded, and no partial transfer SHALL complete.
REQ-024 Operation SHALL resume on the first edge with rst_ni=1, with channel 0 at highest priority.

Structure
REQ-025 Shared package mux_pkg SHALL hold NUM_CH=4, DEFAULT_DATA_W=8 and typedef ch_idx_t (2-bit channel index).
REQ-026 Arbitration SHALL be a sub-module rr_arbiter4 (inputs req, ptr; outputs one-hot grant and grant index); the output register and ptr register SHALL stay in mux4x1_rr.

Verification
REQ-027 The bench SHALL cover: reset, then valid_i=0001, x_i[0]=8'hA5, ready_i=1 -> next cycle valid_o=1, y_o=A5, sel_o=0, ptr=1.
REQ-028 The bench SHALL cover: valid_i=1111 held, x_i[k]=8'h10+k, ready_i=1 -> y_o sequence 10,11,12,13,10 on consecutive cycles, valid_o continuously 1.
REQ-029 The bench SHALL cover: valid_o=1, y_o=11, ready_i=0 for 3 cycles with valid_i=1111 -> y_o stays 11, ready_o=0000; after ready_i=1, the next word is 12.
REQ-030 The bench SHALL cover: ptr=3, valid_i=0110 -> channel 1 granted (wrap), sel_o=1, ptr becomes 2.
REQ-031 The bench SHALL cover: valid_o=1 and ready_i=0, then rst_ni=0 for one edge -> valid_o=0, y_o=0, sel_o=0; the next grant with valid_i=1111 is channel 0.
REQ-032 The bench SHALL cover: valid_o=1, ready_i=1, valid_i=0000 -> valid_o=0 next cycle, y_o unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: constants and types shared by the round-robin 4:1 merge.
//   NUM_CH         - number of input channels
//   DEFAULT_DATA_W - default data-path width
//   ch_idx_t       - 2-bit channel index
package mux_pkg;
    localparam int NUM_CH         = 4;
    localparam int DEFAULT_DATA_W = 8;

    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin arbiter.
// Scans req starting at ptr and wrapping modulo 4; the first set bit wins.
//   i_req   - per-channel request
//   i_ptr   - highest-priority channel for this cycle
//   o_grant - one-hot grant (all zero when no request)
//   o_idx   - index of the granted channel (ptr when nothing granted)
//   o_any   - at least one request present
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  ch_idx_t           i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output ch_idx_t           o_idx,
    output logic              o_any
);

    ch_idx_t w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = i_ptr;
        o_any   = 1'b0;
        w_cand  = i_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            // 2-bit add wraps 3 -> 0 naturally
            w_cand = i_ptr + ch_idx_t'(i);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux4x1_rr.sv
// mux4x1_rr: four valid/ready channels merged round-robin into one
// registered valid/ready output.
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset
//   x_i     - channel data, x_i[k] for channel k
//   valid_i - per-channel valid
//   ready_o - per-channel ready (at most one bit set)
//   y_o     - merged output data
//   sel_o   - channel that y_o came from
//   valid_o - output register holds a word
//   ready_i - downstream accepts
module mux4x1_rr
    import mux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
)(
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  x_i,
    input  logic [NUM_CH-1:0]              valid_i,
    output logic [NUM_CH-1:0]              ready_o,
    output logic [DATA_W-1:0]              y_o,
    output ch_idx_t                        sel_o,
    output logic                           valid_o,
    input  logic                           ready_i
);

    logic [DATA_W-1:0] r_y;
    ch_idx_t           r_sel;
    logic              r_valid;
    ch_idx_t           r_ptr;

    logic [NUM_CH-1:0] w_grant;
    ch_idx_t           w_idx;
    logic              w_any;
    logic              w_load_en;

    rr_arbiter4 u_arb (
        .i_req   (valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Output register is free when empty or being drained this cycle.
    assign w_load_en = !r_valid || ready_i;

    // Reset gating keeps ready low so no transfer is seen during reset.
    assign ready_o = (rst_ni && w_load_en) ? w_grant : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_y     <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_y     <= x_i[w_idx];
                r_sel   <= w_idx;
                r_valid <= 1'b1;
                r_ptr   <= w_idx + ch_idx_t'(1);
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign y_o     = r_y;
    assign sel_o   = r_sel;
    assign valid_o = r_valid;

endmodule
